mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1: memory read latency in cycles (legal 1..3).
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  instruction-fetch read request; held until if_ack.
REQ-005 if_addr  in  16  instruction-fetch address.
REQ-006 if_ack  out  1  one-cycle pulse: fetch request issued to memory.
REQ-007 if_rvalid  out  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  out  16  fetched instruction word.
REQ-009 dt_req  in  1  data-port request; held until dt_ack.
REQ-010 dt_we  in  1  data-port write enable (1 = write, 0 = read).
REQ-011 dt_addr  in  16  data-port address.
REQ-012 dt_wdata  in  16  data-port write data.
REQ-013 dt_ack  out  1  one-cycle pulse: data request issued to memory.
REQ-014 dt_rvalid  out  1  one-cycle pulse: dt_rdata valid (reads only).
REQ-015 dt_rdata  out  16  data read result.
REQ-016 mem_en  out  1  memory access strobe.
REQ-017 mem_we  out  1  memory write strobe, qualified by mem_en.
REQ-018 mem_addr  out  16  memory address.
REQ-019 mem_wdata  out  16  memory write data.
REQ-020 mem_rdata  in  16  memory read data, valid READ_LAT cycles after the mem_en cycle.

Function
REQ-021 The block SHALL run FSM states IDLE, ACCESS, WAIT, RESP, with one transaction outstanding at a time.
REQ-022 In IDLE, if any req is high, the block SHALL select a winner, register its id, addr, we and wdata, and enter ACCESS next cycle; otherwise it SHALL stay in IDLE.
REQ-023 Arbitration SHALL be round-robin: on a simultaneous request the port not granted last wins; a lone request always wins.
REQ-024 The last-grant flag SHALL update only on a grant.
REQ-025 In ACCESS (exactly one cycle), mem_en=1, mem_we=registered we, mem_addr/mem_wdata=registered values, and the winner's ack=1.
REQ-026 From ACCESS, a write SHALL return to IDLE; a read SHALL enter WAIT.
REQ-027 The instruction port SHALL always be a read (mem_we=0).
REQ-028 WAIT SHALL last READ_LAT cycles, capturing mem_rdata on its last cycle, then enter RESP.
REQ-029 In RESP (one cycle), the winner's rvalid=1 and its rdata=the captured word, then the FSM returns to IDLE.
REQ-030 Latency from grant cycle N: ack at N+1; read rvalid at N+2+READ_LAT.
REQ-031 Outside ACCESS, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-032 A req dropped before its grant SHALL be ignored; req changes after grant SHALL not affect the transaction in flight.
REQ-033 A port's rdata SHALL hold its last value until its next rvalid.

Reset
REQ-034 While reset_n=0, all outputs SHALL be 0, the FSM SHALL be IDLE, the WAIT counter 0, and the last-grant flag = instruction port, so the first tie goes to data.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately with no ack or rvalid afterwards; the first grant occurs no earlier than the first edge after deassertion.

Structure
REQ-036 A shared package SHALL hold the FSM state type, the port-id constants (PORT_IF, PORT_DT) and the 16-bit word width constant.
REQ-037 Round-robin selection SHALL be one sub-module, mem_arb_rr: inputs req pair and last-grant flag; output winner id.

Verification
REQ-038 if_req=1, if_addr=0x0040, mem_rdata=0xA5A5, READ_LAT=1, grant at cycle N -> if_ack at N+1 with mem_addr=0x0040, mem_we=0; if_rvalid at N+3 with if_rdata=0xA5A5.
REQ-039 dt_req=1, dt_we=1, dt_addr=0x0100, dt_wdata=0x1234 -> one ACCESS cycle with mem_en=1, mem_we=1, mem_addr=0x0100, mem_wdata=0x1234, dt_ack=1; no dt_rvalid.
REQ-040 if_req and dt_req both held high from reset release -> grants alternate DT, IF, DT, IF.
REQ-041 READ_LAT=3, data read at 0x0200 -> dt_rvalid exactly 5 cycles after grant; mem_en high for exactly 1 cycle.
REQ-042 reset_n pulsed low during WAIT of a read -> all outputs 0 at once; no rvalid afterwards; next request granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

  localparam int WORD_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DT = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-port round-robin winner selection
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic dt_req,
  input  logic last_grant,
  output logic winner
);

  // On a tie the port that did not win last time goes; a lone request always wins.
  always_comb begin
    winner = PORT_IF;
    if (if_req && dt_req) begin
      winner = ~last_grant;
    end else if (dt_req) begin
      winner = PORT_DT;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter for fetch and data ports onto one memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              dt_req,
  input  logic              dt_we,
  input  logic [WORD_W-1:0] dt_addr,
  input  logic [WORD_W-1:0] dt_wdata,
  output logic              dt_ack,
  output logic              dt_rvalid,
  output logic [WORD_W-1:0] dt_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_t            state;
  logic [1:0]        wait_cnt;
  logic              last_grant;
  logic              cur_id;
  logic              cur_we;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [WORD_W-1:0] if_rdata_q;
  logic [WORD_W-1:0] dt_rdata_q;
  logic              winner;

  mem_arb_rr u_rr (
    .if_req     (if_req),
    .dt_req     (dt_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= 2'd0;
      last_grant <= PORT_IF;
      cur_id     <= PORT_IF;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      if_rdata_q <= '0;
      dt_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (if_req || dt_req) begin
            cur_id     <= winner;
            last_grant <= winner;
            // The fetch port can never write, so its grant forces a read.
            cur_we     <= (winner == PORT_DT) && dt_we;
            cur_addr   <= (winner == PORT_DT) ? dt_addr : if_addr;
            cur_wdata  <= (winner == PORT_DT) ? dt_wdata : '0;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          wait_cnt <= 2'd0;
          state    <= cur_we ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == LAST_CNT) begin
            if (cur_id == PORT_DT) begin
              dt_rdata_q <= mem_rdata;
            end else begin
              if_rdata_q <= mem_rdata;
            end
            wait_cnt <= 2'd0;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = mem_en && cur_we;
  assign mem_addr  = mem_en ? cur_addr : '0;
  assign mem_wdata = mem_en ? cur_wdata : '0;

  assign if_ack    = mem_en && (cur_id == PORT_IF);
  assign dt_ack    = mem_en && (cur_id == PORT_DT);
  assign if_rvalid = (state == ST_RESP) && (cur_id == PORT_IF);
  assign dt_rvalid = (state == ST_RESP) && (cur_id == PORT_DT);
  assign if_rdata  = if_rdata_q;
  assign dt_rdata  = dt_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven bench for mem_arbiter with READ_LAT 1 and 3
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        dt_req = 1'b0;
  logic        dt_we = 1'b0;
  logic [15:0] dt_addr = '0;
  logic [15:0] dt_wdata = '0;

  logic        if_ack1, if_rvalid1, dt_ack1, dt_rvalid1, mem_en1, mem_we1;
  logic [15:0] if_rdata1, dt_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ack3, if_rvalid3, dt_ack3, dt_rvalid3, mem_en3, mem_we3;
  logic [15:0] if_rdata3, dt_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.READ_LAT(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .dt_ack(dt_ack1), .dt_rvalid(dt_rvalid1), .dt_rdata(dt_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  mem_arbiter #(.READ_LAT(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .dt_ack(dt_ack3), .dt_rvalid(dt_rvalid3), .dt_rdata(dt_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  // Memory model: contents are addr ^ 0xA5E5, read data only valid exactly READ_LAT cycles after mem_en.
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'hA5E5;
  endfunction

  logic [16:0] p1 = '0;
  logic [16:0] p3a = '0, p3b = '0, p3c = '0;
  always @(posedge clock) begin
    p1  <= (mem_en1 && !mem_we1) ? {1'b1, mem_val(mem_addr1)} : 17'd0;
    p3a <= (mem_en3 && !mem_we3) ? {1'b1, mem_val(mem_addr3)} : 17'd0;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mem_rdata1 = p1[16] ? p1[15:0] : 16'hDEAD;
  assign mem_rdata3 = p3c[16] ? p3c[15:0] : 16'hDEAD;

  typedef struct {
    logic        rst;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dd;
    logic        e_ifack;
    logic        e_ifrv;
    logic [15:0] e_ifrd;
    logic        e_dtack;
    logic        e_dtrv;
    logic [15:0] e_dtrd;
    logic        e_en;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int ack_cyc, rv_cyc, en_cnt, rv_cnt, hits;
    logic [15:0] rd_seen;

    //             rst ir ia       dr dw da       dd        ifack ifrv ifrd     dtack dtrv dtrd     en we addr     wd
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0040, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hA5A5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5A5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 1, 1, 16'h0100, 16'h1234, 0, 0, 16'hA5A5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 1, 1, 16'h0100, 16'h1234, 0, 0, 16'hA5A5, 1, 0, 16'h0000, 1, 1, 16'h0100, 16'h1234});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5A5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5A5, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0020, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'hA5C5, 1, 0, 16'h0010, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 1, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hA5F5, 1, 0, 16'hA5C5, 1, 0, 16'h0020, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hA5F5, 0, 1, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 1, 0, 16'h0020, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5F5, 0, 0, 16'hA5C5, 1, 0, 16'h0010, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 1, 1, 16'h0300, 16'h5555, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0050, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0777, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hA5F5, 0, 0, 16'hA5C5, 1, 0, 16'h0050, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5F5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'hA5B5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'hA5B5, 0, 0, 16'hA5C5, 0, 0, 16'h0000, 16'h0000});

    #1;
    foreach (tbl[i]) begin
      reset_n  = tbl[i].rst;
      if_req   = tbl[i].ir;
      if_addr  = tbl[i].ia;
      dt_req   = tbl[i].dr;
      dt_we    = tbl[i].dw;
      dt_addr  = tbl[i].da;
      dt_wdata = tbl[i].dd;
      @(negedge clock);
      check("if_ack",    i, {15'd0, if_ack1},    {15'd0, tbl[i].e_ifack});
      check("if_rvalid", i, {15'd0, if_rvalid1}, {15'd0, tbl[i].e_ifrv});
      check("if_rdata",  i, if_rdata1,           tbl[i].e_ifrd);
      check("dt_ack",    i, {15'd0, dt_ack1},    {15'd0, tbl[i].e_dtack});
      check("dt_rvalid", i, {15'd0, dt_rvalid1}, {15'd0, tbl[i].e_dtrv});
      check("dt_rdata",  i, dt_rdata1,           tbl[i].e_dtrd);
      check("mem_en",    i, {15'd0, mem_en1},    {15'd0, tbl[i].e_en});
      check("mem_we",    i, {15'd0, mem_we1},    {15'd0, tbl[i].e_we});
      check("mem_addr",  i, mem_addr1,           tbl[i].e_addr);
      check("mem_wdata", i, mem_wdata1,          tbl[i].e_wd);
      next_cycle();
    end

    // READ_LAT=3 data read: grant at c=0, ack at c=1, rvalid at c=5, one mem_en cycle.
    reset_n = 1'b0;
    if_req  = 1'b0;
    dt_req  = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    dt_req  = 1'b1;
    dt_we   = 1'b0;
    dt_addr = 16'h0200;
    ack_cyc = -1;
    rv_cyc  = -1;
    en_cnt  = 0;
    rv_cnt  = 0;
    rd_seen = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (mem_en3) en_cnt++;
      if (dt_ack3 && ack_cyc < 0) ack_cyc = c;
      if (dt_rvalid3) begin
        rv_cnt++;
        if (rv_cyc < 0) begin
          rv_cyc  = c;
          rd_seen = dt_rdata3;
        end
      end
      next_cycle();
      if (ack_cyc >= 0) dt_req = 1'b0;
    end
    check("lat3_ack_cycle",  100, 16'(ack_cyc), 16'd1);
    check("lat3_rv_cycle",   100, 16'(rv_cyc),  16'd5);
    check("lat3_rv_count",   100, 16'(rv_cnt),  16'd1);
    check("lat3_en_count",   100, 16'(en_cnt),  16'd1);
    check("lat3_rdata",      100, rd_seen,      16'hA7E5);
    check("lat1_dt_rdata",   100, dt_rdata1,    16'hA7E5);

    // Reset pulsed during WAIT of a fetch read aborts it immediately.
    if_req  = 1'b1;
    if_addr = 16'h0040;
    @(negedge clock);
    next_cycle();
    @(negedge clock);
    check("abort_if_ack", 200, {15'd0, if_ack1}, 16'd1);
    next_cycle();
    if_req = 1'b0;
    check("abort_in_wait_en", 200, {15'd0, mem_en1}, 16'd0);
    reset_n = 1'b0;
    #1;
    check("abort_dt_rdata",  201, dt_rdata1, 16'h0000);
    check("abort_if_rdata",  201, if_rdata1, 16'h0000);
    check("abort_rvalid",    201, {14'd0, if_rvalid1, dt_rvalid1}, 16'd0);
    check("abort_mem",       201, mem_addr1 | mem_wdata1 | {14'd0, mem_en1, mem_we1}, 16'd0);
    check("abort_dut3_rdata", 201, dt_rdata3, 16'h0000);
    next_cycle();
    reset_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (if_rvalid1 || if_ack1 || dt_rvalid1 || dt_ack1 || if_rvalid3 || if_ack3) hits++;
      next_cycle();
    end
    check("abort_no_late_pulse", 202, 16'(hits), 16'd0);

    dt_req   = 1'b1;
    dt_we    = 1'b1;
    dt_addr  = 16'h0400;
    dt_wdata = 16'hBEEF;
    ack_cyc  = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (dt_ack1 && ack_cyc < 0) begin
        ack_cyc = c;
        check("post_reset_addr",  203, mem_addr1,  16'h0400);
        check("post_reset_wdata", 203, mem_wdata1, 16'hBEEF);
        check("post_reset_we",    203, {15'd0, mem_we1}, 16'd1);
      end
      next_cycle();
      if (ack_cyc >= 0) dt_req = 1'b0;
    end
    check("post_reset_ack_cycle", 203, 16'(ack_cyc), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
